// File: rtl/ir_txrx_ctrl.sv
// IR pulse-train capture and replay controller with an 8-bit register port.
// Define IR_CARRIER_EN to build the modulated-carrier generator and CARR_DIV register.
module ir_txrx_ctrl #(
  parameter int         DEPTH        = 32,
  parameter int         CNT_W        = 16,
  parameter logic [7:0] RST_PRESCALE = 8'd11
) (
  input  logic       CLKI,
  input  logic       RST,
  input  logic       IRIN,
  output logic       IROUT,
  input  logic [3:0] ADRI,
  input  logic       CSI,
  input  logic       DENI,
  input  logic       WEI,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA,
  input  logic       EXE,
  input  logic       LEARN,
  output logic       BUSY,
  output logic       DRDY,
  output logic       ERR
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [CNT_W-1:0] DUR_MAX = '1;
`ifdef IR_CARRIER_EN
  localparam logic CARR_EN = 1'b1;
`else
  localparam logic CARR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, LWAIT = 2'd1, LRUN = 2'd2, TX = 2'd3} state_t;
  state_t state_r, state_next;

  logic [CNT_W-1:0] mem [DEPTH];
  logic [1:0]       ctrl_r;
  logic [PW-1:0]    ptr_r, tx_idx_r, tx_idx_next_s;
  logic [CW-1:0]    count_r;
  logic [7:0]       prescale_r, pre_cnt_r, data_lo_r, rdata_r, rd_mux_s, carr_div_rd_s;
  logic [CNT_W-1:0] dur_r, tx_entry_s;
  logic [15:0]      ptr_word_s;
  logic sync1_r, sync2_r, level_r, err_r, busy_r, drdy_r, irout_r;
  logic acc_s, wr_s, rd_s, cfg_wr_s, tick_s, active_s, tx_end_s, tx_final_s;
  logic err_set_s, done_s, store_s, dur_clr_s, dur_inc_s, tx_adv_s, count_clr_s;
  logic mark_next_s, mark_drive_s;

  assign acc_s      = CSI & DENI;
  assign wr_s       = acc_s & WEI;
  assign rd_s       = acc_s & ~WEI;
  assign cfg_wr_s   = wr_s & (state_r == IDLE);
  assign tick_s     = (pre_cnt_r == prescale_r);
  assign active_s   = ~sync2_r ^ ctrl_r[1];
  assign ptr_word_s = 16'(mem[ptr_r]);
  assign tx_entry_s = mem[tx_idx_r];
  // A zero-length entry still occupies one tick.
  assign tx_end_s   = (tx_entry_s == '0) || (dur_r == tx_entry_s - CNT_W'(1));
  assign tx_final_s = (CW'(tx_idx_r) == count_r - CW'(1));
  assign tx_idx_next_s = (state_r == IDLE) ? '0 : (tx_adv_s ? tx_idx_r + PW'(1) : tx_idx_r);
  assign mark_next_s   = (state_next == TX) && !tx_idx_next_s[0];

  always_ff @(posedge CLKI) begin
    if (RST) state_r <= IDLE;
    else     state_r <= state_next;
  end

  always_comb begin
    state_next  = state_r;
    err_set_s   = 1'b0;
    done_s      = 1'b0;
    store_s     = 1'b0;
    dur_clr_s   = 1'b0;
    dur_inc_s   = 1'b0;
    tx_adv_s    = 1'b0;
    count_clr_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (LEARN && EXE) begin
          err_set_s = 1'b1;
        end else if (LEARN) begin
          state_next  = LWAIT;
          count_clr_s = 1'b1;
        end else if (EXE) begin
          if (count_r == '0) begin
            err_set_s = 1'b1;
          end else begin
            state_next = TX;
            dur_clr_s  = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      LWAIT: begin
        if (active_s) begin
          state_next = LRUN;
          dur_clr_s  = 1'b1;
        end else begin
          state_next = LWAIT;
        end
      end
      LRUN: begin
        if (active_s != level_r) begin
          if (count_r == DEPTH_C) begin
            err_set_s  = 1'b1;
            done_s     = 1'b1;
            state_next = IDLE;
          end else begin
            store_s   = 1'b1;
            dur_clr_s = 1'b1;
          end
        end else if (dur_r == DUR_MAX) begin
          err_set_s  = active_s;
          done_s     = 1'b1;
          state_next = IDLE;
        end else begin
          dur_inc_s = tick_s;
        end
      end
      TX: begin
        if (tick_s && tx_end_s) begin
          if (tx_final_s) begin
            done_s     = 1'b1;
            state_next = IDLE;
          end else begin
            tx_adv_s  = 1'b1;
            dur_clr_s = 1'b1;
          end
        end else begin
          dur_inc_s = tick_s;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef IR_CARRIER_EN
  logic [7:0] carr_div_r, carr_cnt_r;
  logic       carr_r, mark_start_s, carr_next_s;
  assign mark_start_s  = mark_next_s && !((state_r == TX) && !tx_idx_r[0]);
  assign carr_next_s   = mark_start_s ? 1'b1 : ((carr_cnt_r == carr_div_r) ? ~carr_r : carr_r);
  assign mark_drive_s  = ctrl_r[0] ? carr_next_s : 1'b1;
  assign carr_div_rd_s = carr_div_r;

  // Carrier phase restarts high at every mark start.
  always_ff @(posedge CLKI) begin
    if (RST) begin
      carr_div_r <= 8'd157;
      carr_r     <= 1'b1;
      carr_cnt_r <= 8'd0;
    end else begin
      if (cfg_wr_s && ADRI == 4'd6) carr_div_r <= WDATA;
      carr_r <= carr_next_s;
      if (mark_start_s || carr_cnt_r == carr_div_r) carr_cnt_r <= 8'd0;
      else                                           carr_cnt_r <= carr_cnt_r + 8'd1;
    end
  end
`else
  assign mark_drive_s  = 1'b1;
  assign carr_div_rd_s = 8'd0;
`endif

  always_ff @(posedge CLKI) begin
    if (RST) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      level_r   <= 1'b0;
      dur_r     <= '0;
      pre_cnt_r <= 8'd0;
      tx_idx_r  <= '0;
      busy_r    <= 1'b0;
      drdy_r    <= 1'b0;
      irout_r   <= 1'b0;
    end else begin
      sync1_r <= IRIN;
      sync2_r <= sync1_r;
      if (state_r == LWAIT && state_next == LRUN) level_r <= 1'b1;
      else if (store_s)                           level_r <= active_s;
      if (dur_clr_s)      dur_r <= '0;
      else if (dur_inc_s) dur_r <= dur_r + CNT_W'(1);
      if ((state_next != IDLE && state_next != state_r) || tick_s) pre_cnt_r <= 8'd0;
      else                                                         pre_cnt_r <= pre_cnt_r + 8'd1;
      tx_idx_r <= tx_idx_next_s;
      busy_r   <= (state_next != IDLE);
      drdy_r   <= done_s;
      irout_r  <= mark_next_s & mark_drive_s;
    end
  end

  always_ff @(posedge CLKI) begin
    if (RST) begin
      ctrl_r     <= 2'd0;
      ptr_r      <= '0;
      count_r    <= '0;
      prescale_r <= RST_PRESCALE;
      data_lo_r  <= 8'd0;
      err_r      <= 1'b0;
      rdata_r    <= 8'd0;
    end else begin
      if (wr_s && ADRI == 4'd0) ctrl_r <= {WDATA[1], WDATA[0] & CARR_EN};
      if (cfg_wr_s && ADRI == 4'd2)                    ptr_r <= WDATA[PW-1:0];
      else if ((cfg_wr_s || rd_s) && ADRI == 4'd4)      ptr_r <= ptr_r + PW'(1);
      if (count_clr_s)                    count_r <= '0;
      else if (store_s)                   count_r <= count_r + CW'(1);
      else if (cfg_wr_s && ADRI == 4'd5)  count_r <= (WDATA > 8'(DEPTH)) ? DEPTH_C : CW'(WDATA);
      if (cfg_wr_s && ADRI == 4'd7) prescale_r <= WDATA;
      if (cfg_wr_s && ADRI == 4'd3) data_lo_r  <= WDATA;
      if (err_set_s)                  err_r <= 1'b1;
      else if (wr_s && ADRI == 4'd1)  err_r <= 1'b0;
      if (rd_s) rdata_r <= rd_mux_s;
    end
  end

  // Pulse buffer keeps its contents across reset.
  always_ff @(posedge CLKI) begin
    if (!RST && store_s)                          mem[count_r[PW-1:0]] <= dur_r;
    else if (!RST && cfg_wr_s && ADRI == 4'd4)    mem[ptr_r] <= CNT_W'({WDATA, data_lo_r});
  end

  always_comb begin
    rd_mux_s = 8'd0;
    case (ADRI)
      4'd0:    rd_mux_s = {6'd0, ctrl_r};
      4'd1:    rd_mux_s = {5'd0, err_r, state_r};
      4'd2:    rd_mux_s = 8'(ptr_r);
      4'd3:    rd_mux_s = ptr_word_s[7:0];
      4'd4:    rd_mux_s = ptr_word_s[15:8];
      4'd5:    rd_mux_s = 8'(count_r);
      4'd6:    rd_mux_s = carr_div_rd_s;
      4'd7:    rd_mux_s = prescale_r;
      default: rd_mux_s = 8'd0;
    endcase
  end

  assign IROUT = irout_r;
  assign RDATA = rdata_r;
  assign BUSY  = busy_r;
  assign DRDY  = drdy_r;
  assign ERR   = err_r;
endmodule

// File: tb/tb_ir_txrx_ctrl.sv
// Directed scoreboard bench for ir_txrx_ctrl (DEPTH=4, CNT_W=9).
module tb_ir_txrx_ctrl;
  logic       CLKI = 1'b0, RST = 1'b1, IRIN = 1'b1;
  logic       CSI = 1'b0, DENI = 1'b0, WEI = 1'b0, EXE = 1'b0, LEARN = 1'b0;
  logic [3:0] ADRI = 4'd0;
  logic [7:0] WDATA = 8'd0;
  logic [7:0] RDATA;
  logic       IROUT, BUSY, DRDY, ERR;
  int         total = 0, bad = 0;
  logic [31:0] sb_q[$];

  ir_txrx_ctrl #(.DEPTH(4), .CNT_W(9)) dut (
    .CLKI(CLKI), .RST(RST), .IRIN(IRIN), .IROUT(IROUT), .ADRI(ADRI), .CSI(CSI),
    .DENI(DENI), .WEI(WEI), .WDATA(WDATA), .RDATA(RDATA), .EXE(EXE), .LEARN(LEARN),
    .BUSY(BUSY), .DRDY(DRDY), .ERR(ERR)
  );

  always #5 CLKI = ~CLKI;

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = sb_q.pop_front();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = sb_q.pop_front();
    total++;
    assert (obs + 32'd1 >= exp && obs <= exp + 32'd1) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d+-1", tag, obs, exp);
    end
  endtask

  task automatic sig_chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    sb_q.push_back(exp);
    check(tag, obs);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge CLKI); CSI = 1'b1; DENI = 1'b1; WEI = 1'b1; ADRI = a; WDATA = d;
    @(negedge CLKI); CSI = 1'b0; DENI = 1'b0; WEI = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge CLKI); CSI = 1'b1; DENI = 1'b1; WEI = 1'b0; ADRI = a;
    @(negedge CLKI); CSI = 1'b0; DENI = 1'b0;
    d = RDATA;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    sb_q.push_back(32'(exp));
    rd(a, d);
    check(tag, 32'(d));
  endtask

  task automatic rd_tol(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    sb_q.push_back(32'(exp));
    rd(a, d);
    check_tol(tag, 32'(d));
  endtask

  task automatic pulse(input logic exe, input logic lrn);
    @(negedge CLKI); EXE = exe; LEARN = lrn;
    @(negedge CLKI); EXE = 1'b0; LEARN = 1'b0;
  endtask

  task automatic hold(input logic v, input int n);
    IRIN = v;
    repeat (n) @(negedge CLKI);
  endtask

  task automatic wait_drdy(input string tag, input int bound, output int n);
    n = 0;
    while (DRDY !== 1'b1 && n < bound) begin
      @(negedge CLKI);
      n++;
    end
    sig_chk(tag, 32'(DRDY), 32'd1);
  endtask

  initial begin
    int n;
    int drdy_seen;
    logic [7:0] carr_pat;
    logic [7:0] carr_div_rst;
    logic [1:0] ctrl_b0;
`ifdef IR_CARRIER_EN
    carr_pat = 8'b0011_0011;  // bit i is sample i, first sample high
    carr_div_rst = 8'd157;
    ctrl_b0 = 2'd1;
`else
    carr_pat = 8'b1111_1111;
    carr_div_rst = 8'd0;
    ctrl_b0 = 2'd0;
`endif
    repeat (3) @(negedge CLKI);
    sig_chk("rst_irout", 32'(IROUT), 32'd0);
    sig_chk("rst_busy", 32'(BUSY), 32'd0);
    sig_chk("rst_drdy", 32'(DRDY), 32'd0);
    sig_chk("rst_err", 32'(ERR), 32'd0);
    sig_chk("rst_rdata", 32'(RDATA), 32'd0);
    RST = 1'b0;
    rd_chk("rst_prescale", 4'd7, 8'd11);
    rd_chk("rst_carr_div", 4'd6, carr_div_rst);
    rd_chk("rst_ctrl", 4'd0, 8'd0);
    rd_chk("rst_count", 4'd5, 8'd0);
    rd_chk("rst_status", 4'd1, 8'd0);
    rd_chk("unmapped_rd", 4'd9, 8'd0);

    // Replay 10,5,10 with one tick per clock.
    wr(4'd2, 8'd0);
    wr(4'd3, 8'd10); wr(4'd4, 8'd0);
    wr(4'd3, 8'd5);  wr(4'd4, 8'd0);
    wr(4'd3, 8'd10); wr(4'd4, 8'd0);
    rd_chk("ptr_after_wr", 4'd2, 8'd3);
    wr(4'd5, 8'd3); wr(4'd7, 8'd0); wr(4'd0, 8'd0);
    wr(4'd2, 8'd0);
    rd_chk("buf0_lo", 4'd3, 8'd10);
    rd_chk("buf0_hi", 4'd4, 8'd0);
    rd_chk("ptr_after_rd", 4'd2, 8'd1);
    pulse(1'b1, 1'b0);
    sig_chk("tx_busy", 32'(BUSY), 32'd1);
    for (int i = 0; i < 26; i++) begin
      sig_chk("tx_irout", 32'(IROUT), (i < 10 || (i >= 15 && i < 25)) ? 32'd1 : 32'd0);
      if (i < 25) @(negedge CLKI);
    end
    sig_chk("tx_drdy", 32'(DRDY), 32'd1);
    sig_chk("tx_busy_end", 32'(BUSY), 32'd0);
    @(negedge CLKI);
    sig_chk("tx_drdy_one", 32'(DRDY), 32'd0);
    rd_chk("tx_count_kept", 4'd5, 8'd3);

    // Single mark of 8 ticks with carrier requested.
    wr(4'd6, 8'd1); wr(4'd0, 8'd1);
    rd_chk("ctrl_b0", 4'd0, 8'(ctrl_b0));
    wr(4'd2, 8'd0); wr(4'd3, 8'd8); wr(4'd4, 8'd0); wr(4'd5, 8'd1);
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      sig_chk("carr_irout", 32'(IROUT), (i < 8) ? 32'(carr_pat[i]) : 32'd0);
      if (i < 8) @(negedge CLKI);
    end
    wr(4'd0, 8'd0);

    // Start errors.
    wr(4'd5, 8'd0);
    pulse(1'b1, 1'b0);
    sig_chk("exe_empty_err", 32'(ERR), 32'd1);
    sig_chk("exe_empty_busy", 32'(BUSY), 32'd0);
    wr(4'd1, 8'd0);
    sig_chk("err_clear", 32'(ERR), 32'd0);
    wr(4'd5, 8'd2);
    pulse(1'b1, 1'b1);
    sig_chk("both_err", 32'(ERR), 32'd1);
    rd_chk("both_status", 4'd1, 8'h04);
    wr(4'd1, 8'd0);

    // Capture 20/30/40 then idle timeout.
    pulse(1'b0, 1'b1);
    rd_chk("lrn_count_clr", 4'd5, 8'd0);
    rd_chk("lrn_status", 4'd1, 8'h01);
    hold(1'b0, 20); hold(1'b1, 30); hold(1'b0, 40);
    IRIN = 1'b1;
    wait_drdy("lrn_drdy", 700, n);
    sig_chk("lrn_timeout_len", 32'(n >= 500 && n <= 530), 32'd1);
    sig_chk("lrn_err", 32'(ERR), 32'd0);
    sig_chk("lrn_busy", 32'(BUSY), 32'd0);
    rd_chk("lrn_count", 4'd5, 8'd3);
    wr(4'd2, 8'd0);
    rd_tol("lrn_e0", 4'd3, 8'd20); rd_chk("lrn_e0_hi", 4'd4, 8'd0);
    rd_tol("lrn_e1", 4'd3, 8'd30); rd_chk("lrn_e1_hi", 4'd4, 8'd0);
    rd_tol("lrn_e2", 4'd3, 8'd40);

    // Inverted input: idle-high now counts as mark and times out with error.
    wr(4'd0, 8'd2);
    pulse(1'b0, 1'b1);
    @(negedge CLKI);
    rd_chk("inv_status_lrun", 4'd1, 8'h02);
    wait_drdy("inv_drdy", 700, n);
    sig_chk("inv_err", 32'(ERR), 32'd1);
    rd_chk("inv_count", 4'd5, 8'd0);
    wr(4'd1, 8'd0); wr(4'd0, 8'd0);

    // Overflow: six edges into a four-entry buffer.
    pulse(1'b0, 1'b1);
    hold(1'b0, 5); hold(1'b1, 5); hold(1'b0, 5); hold(1'b1, 5); hold(1'b0, 5);
    IRIN = 1'b1;
    wait_drdy("ovf_drdy", 20, n);
    sig_chk("ovf_err", 32'(ERR), 32'd1);
    rd_chk("ovf_count", 4'd5, 8'd4);
    rd_chk("ovf_status", 4'd1, 8'h04);
    wr(4'd1, 8'd0);
    rd_chk("ovf_status_clr", 4'd1, 8'h00);

    // Pointer wrap, 9-bit entry, COUNT saturation.
    wr(4'd2, 8'd3); wr(4'd3, 8'hAB); wr(4'd4, 8'hFF);
    rd_chk("ptr_wrap_wr", 4'd2, 8'd0);
    wr(4'd2, 8'd3);
    rd_chk("e9_lo", 4'd3, 8'hAB);
    rd_chk("e9_hi", 4'd4, 8'h01);
    rd_chk("ptr_wrap_rd", 4'd2, 8'd0);
    wr(4'd5, 8'd200);
    rd_chk("count_sat", 4'd5, 8'd4);

    // Reset during replay.
    wr(4'd2, 8'd0);
    wr(4'd3, 8'd100); wr(4'd4, 8'd0);
    wr(4'd3, 8'd50);  wr(4'd4, 8'd0);
    wr(4'd5, 8'd2); wr(4'd7, 8'd0);
    pulse(1'b1, 1'b0);
    repeat (5) @(negedge CLKI);
    wr(4'd7, 8'd5); wr(4'd2, 8'd3);
    rd_chk("busy_prescale_kept", 4'd7, 8'd0);
    rd_chk("busy_ptr_kept", 4'd2, 8'd2);
    sig_chk("pre_rst_irout", 32'(IROUT), 32'd1);
    RST = 1'b1;
    @(negedge CLKI);
    sig_chk("abort_irout", 32'(IROUT), 32'd0);
    sig_chk("abort_busy", 32'(BUSY), 32'd0);
    sig_chk("abort_drdy", 32'(DRDY), 32'd0);
    RST = 1'b0;
    drdy_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLKI);
      if (DRDY === 1'b1) drdy_seen++;
    end
    sig_chk("abort_no_drdy", 32'(drdy_seen), 32'd0);
    rd_chk("abort_count", 4'd5, 8'd0);
    rd_chk("abort_prescale", 4'd7, 8'd11);
    rd_chk("keep_e0", 4'd3, 8'd100);
    rd_chk("keep_e0_hi", 4'd4, 8'd0);
    rd_chk("keep_e1", 4'd3, 8'd50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ir_txrx_ctrl.md
IR_TXRX_CTRL -- requirements
Module: ir_txrx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 32: pulse-buffer entries, power of two, 4..128.
REQ-002 SHALL have parameter CNT_W, default 16: duration width in ticks, 9..16.
REQ-003 SHALL have parameter RST_PRESCALE, default 8'd11: reset value of the PRESCALE register.
REQ-004 SHALL have ports in this order:
- CLKI  in  1  clock
- RST  in  1  reset
- IRIN  in  1  demodulated IR receiver level, asynchronous
- IROUT  out  1  IR emitter drive
- ADRI  in  4  register address
- CSI  in  1  chip select
- DENI  in  1  data strobe
- WEI  in  1  1 = write, 0 = read
- WDATA  in  8  write data
- RDATA  out  8  read data
- EXE  in  1  start replay, single-cycle pulse
- LEARN  in  1  start capture, single-cycle pulse
- BUSY  out  1  operation in progress
- DRDY  out  1  operation complete, 1-cycle pulse
- ERR  out  1  sticky error
REQ-005 SHALL use one clock, CLKI; RST is synchronous and active-high.

Function
REQ-006 Register map SHALL be:
- 0 CTRL: rw; bit0 carrier enable, bit1 IRIN invert.
- 1 STATUS: ro; {5'b0, ERR, state[1:0]}. Any write clears ERR.
- 2 PTR: rw buffer index.
- 3 DATA_L: low byte.
- 4 DATA_H: high byte.
- 5 COUNT: valid entries.
- 6 CARR_DIV: carrier half-period minus 1, in clocks.
- 7 PRESCALE.
- 8-15: read 0, writes ignored.
REQ-007 Access SHALL occur on CSI&DENI. RDATA SHALL be registered, valid the cycle after the strobe, and held until the next read.
REQ-008 DATA_L write SHALL latch the low byte. DATA_H write SHALL store {WDATA,latched}[CNT_W-1:0] at PTR, then increment PTR.
REQ-009 DATA_L read SHALL return buffer[PTR][7:0]. DATA_H read SHALL return the upper bits, zero-padded, then increment PTR. PTR SHALL wrap DEPTH-1 -> 0.
REQ-010 A COUNT write SHALL saturate at DEPTH.
REQ-011 While BUSY, writes to 2-7 SHALL be ignored; reads are permitted.
REQ-012 A tick SHALL occur every PRESCALE+1 clocks; the prescaler SHALL restart on entry to any non-IDLE state.
REQ-013 IRIN SHALL pass through a 2-flop synchronizer. Active level is synchronized IRIN==0, XOR CTRL.bit1.
REQ-014 FSM states SHALL be IDLE=0, LWAIT=1, LRUN=2, TX=3. BUSY=1 in every state except IDLE.
REQ-015 IDLE start conditions:
- LEARN -> LWAIT, with COUNT=0.
- EXE with COUNT>0 -> TX, starting at entry 0.
- EXE with COUNT==0 -> ERR=1, remain in IDLE.
- LEARN and EXE in the same cycle -> ERR=1, remain in IDLE.
- EXE or LEARN while not IDLE SHALL be ignored.
REQ-016 LWAIT SHALL go to LRUN on the first active level and clear the duration counter.
REQ-017 In LRUN the counter SHALL increment per tick. On each level change, buffer[COUNT] <= counter, COUNT++, counter cleared; entries alternate mark/space, starting with mark.
REQ-018 In LRUN, counter reaching all-ones while inactive SHALL end the capture: nothing stored, go to IDLE, DRDY pulse.
REQ-019 In LRUN, counter reaching all-ones while active SHALL set ERR and end the capture, with a DRDY pulse.
REQ-020 A level change in LRUN with COUNT==DEPTH SHALL set ERR and end the capture, with a DRDY pulse; the change is not stored.
REQ-021 In TX, each entry SHALL last max(entry,1) ticks. Even entries are mark, odd entries are space.
REQ-022 After entry COUNT-1, TX SHALL go to IDLE with a DRDY pulse. COUNT and the buffer SHALL be unchanged.
REQ-023 IROUT SHALL be 0 in space and in IDLE. In mark, IROUT SHALL be the carrier if CTRL.bit0 is set, else 1.
REQ-024 The carrier SHALL start at 1 and toggle every CARR_DIV+1 clocks. Its phase SHALL restart at each mark start.
REQ-025 DRDY SHALL be a one-cycle pulse, asserted the cycle the FSM re-enters IDLE from a capture or replay.

Reset
REQ-026 RST SHALL set:
- state IDLE
- IROUT=0, BUSY=0, DRDY=0, ERR=0, RDATA=0
- CTRL=0, PTR=0, COUNT=0
- CARR_DIV=8'd157
- PRESCALE=RST_PRESCALE
- synchronizer flops to 1
REQ-027 Buffer contents SHALL NOT be cleared by RST.
REQ-028 RST mid-operation SHALL abort within one cycle with no DRDY pulse.

Configuration
REQ-029 With macro IR_CARRIER_EN defined, the carrier generator and CARR_DIV SHALL exist.
REQ-030 Without IR_CARRIER_EN: mark drives IROUT=1, CARR_DIV and CTRL.bit0 read 0, and their writes are ignored.

Verification
REQ-031 Write entries 10,5,10 via DATA_L/H, COUNT=3, PRESCALE=0, CTRL=0, EXE -> IROUT 1 for 10 clocks, then 0 for 5, then 1 for 10; DRDY pulse; BUSY low afterward.
REQ-032 IR_CARRIER_EN, CARR_DIV=1, CTRL=1, one entry 8, PRESCALE=0, EXE -> IROUT pattern 1,1,0,0,1,1,0,0, then 0.
REQ-033 PRESCALE=0, CNT_W=9, LEARN, IRIN low 20 clk / high 30 clk / low 40 clk / then high -> COUNT=3, entries 20,30,40 (±1); timeout after 511 ticks; DRDY pulse.
REQ-034 DEPTH=4, LEARN, 6 edges -> ERR=1, COUNT=4, DRDY pulse; STATUS write clears ERR.
REQ-035 COUNT=0 with EXE -> ERR=1, BUSY stays 0. LEARN+EXE in the same cycle -> ERR=1, state IDLE.
REQ-036 RST asserted mid-TX -> next cycle IROUT=0, BUSY=0, COUNT=0, no DRDY; buffer readback unchanged.
